// File: rtl/divider_par.sv
`default_nettype none
// ============================================================================
// Module      : divider_par
// Description : Multi-cycle signed/unsigned integer divider. Operands are
//               captured one cycle after start, converted to magnitudes and
//               divided by restoring division (one shift cycle plus one
//               trial-subtract cycle per quotient bit). Signs are applied to
//               the final quotient/remainder on the completing edge.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_par #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividendin,
    input  logic [DIVISOR_W-1:0]  divisorin,
    input  logic                  signedin,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  valid,
    output logic                  busy,
    output logic                  error
);

    localparam int CNT_W = $clog2(2 * DIVIDEND_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DIVISOR_W:0]      rem_q;      // partial remainder, one guard bit
    logic [DIVIDEND_W-1:0]   dq_q;       // dividend bits shift out, quotient bits shift in
    logic [DIVISOR_W-1:0]    dvs_q;      // divisor magnitude
    logic                    qneg_q;     // quotient must be negated at the end
    logic                    rneg_q;     // remainder must be negated at the end
    logic                    dvs_zero_q; // divide-by-zero flag for this operation
    logic [DIVIDEND_W-1:0]   quotient_q;
    logic [DIVISOR_W-1:0]    remainder_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    error_q;

    logic                    dd_neg_d;
    logic                    dv_neg_d;
    logic [DIVIDEND_W-1:0]   dd_mag_d;
    logic [DIVISOR_W-1:0]    dv_mag_d;
    logic                    ge_d;
    logic [DIVISOR_W:0]      rem_b_d;
    logic [DIVIDEND_W-1:0]   qmag_d;
    logic [DIVISOR_W-1:0]    rmag_d;
    logic [DIVIDEND_W-1:0]   q_fin_d;
    logic [DIVISOR_W-1:0]    r_fin_d;

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign error     = error_q;

    // Operand magnitudes, trial subtraction and final sign fix-up
    always_comb begin
        dd_neg_d = signedin & dividendin[DIVIDEND_W-1];
        dv_neg_d = signedin & divisorin[DIVISOR_W-1];
        dd_mag_d = dd_neg_d ? (~dividendin + 1'b1) : dividendin;
        dv_mag_d = dv_neg_d ? (~divisorin + 1'b1) : divisorin;

        ge_d     = (rem_q >= {1'b0, dvs_q});
        rem_b_d  = ge_d ? (rem_q - {1'b0, dvs_q}) : rem_q;
        qmag_d   = {dq_q[DIVIDEND_W-1:1], ge_d};
        rmag_d   = rem_b_d[DIVISOR_W-1:0];

        // Most-negative / -1 simply wraps: magnitude 2^(W-1) reads back as itself
        if (dvs_zero_q) begin
            q_fin_d = '1;
            r_fin_d = '0;
        end else begin
            q_fin_d = qneg_q ? (~qmag_d + 1'b1) : qmag_d;
            r_fin_d = rneg_q ? (~rmag_d + 1'b1) : rmag_d;
        end
    end

    // Control FSM, datapath iteration and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dvs_zero_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else if (start) begin
            // A start in any state (including mid-operation) restarts from LOAD
            state_q <= LOAD;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    dq_q       <= dd_mag_d;
                    dvs_q      <= dv_mag_d;
                    rem_q      <= '0;
                    qneg_q     <= dd_neg_d ^ dv_neg_d;
                    rneg_q     <= dd_neg_d;
                    dvs_zero_q <= (divisorin == '0);
                    cnt_q      <= '0;
                    state_q    <= RUN;
                end
                RUN: begin
                    if (!cnt_q[0]) begin
                        // Shift the next dividend bit into the partial remainder
                        rem_q <= {rem_q[DIVISOR_W-1:0], dq_q[DIVIDEND_W-1]};
                        dq_q  <= {dq_q[DIVIDEND_W-2:0], 1'b0};
                    end else begin
                        // Trial subtract, keep the difference if non-negative
                        rem_q <= rem_b_d;
                        dq_q  <= qmag_d;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        valid_q     <= 1'b1;
                        error_q     <= dvs_zero_q;
                        quotient_q  <= q_fin_d;
                        remainder_q <= r_fin_d;
                    end
                end
                default: begin
                    // IDLE and DONE hold everything until the next start
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divider_par.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_par
// Description : Self-checking bench for divider_par: directed table, random
//               vectors against an arithmetic reference, abort, reset and a
//               wide-parameter instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_par;

    localparam int W   = 8;
    localparam int DW  = 7;
    localparam int LAT = 2 * W + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          signedin = 1'b0;
    logic [W-1:0]  dividendin = '0;
    logic [DW-1:0] divisorin = '0;
    logic [W-1:0]  quotient;
    logic [DW-1:0] remainder;
    logic          valid, busy, error;

    logic          start2 = 1'b0;
    logic [15:0]   dividend2 = '0;
    logic [11:0]   divisor2 = '0;
    logic [15:0]   quotient2;
    logic [11:0]   remainder2;
    logic          valid2, busy2, error2;

    int n_chk  = 0;
    int n_fail = 0;

    divider_par #(.DIVIDEND_W(W), .DIVISOR_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .dividendin(dividendin), .divisorin(divisorin), .signedin(signedin),
        .quotient(quotient), .remainder(remainder),
        .valid(valid), .busy(busy), .error(error)
    );

    divider_par #(.DIVIDEND_W(16), .DIVISOR_W(12)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .dividendin(dividend2), .divisorin(divisor2), .signedin(1'b0),
        .quotient(quotient2), .remainder(remainder2),
        .valid(valid2), .busy(busy2), .error(error2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  a;
        logic [DW-1:0] b;
        logic          s;
        logic [W-1:0]  q;
        logic [DW-1:0] r;
        logic          e;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division (SV / and % truncate toward zero)
    function automatic void model(input logic [W-1:0] a, input logic [DW-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [DW-1:0] r, output logic e);
        int ai, bi, qi, ri;
        if (b == '0) begin
            q = '1; r = '0; e = 1'b1;
        end else begin
            if (s) begin
                ai = $signed(a);
                bi = $signed(b);
            end else begin
                ai = int'(a);
                bi = int'(b);
            end
            qi = ai / bi;
            ri = ai % bi;
            q  = qi[W-1:0];
            r  = ri[DW-1:0];
            e  = 1'b0;
        end
    endfunction

    // Call mid-cycle; the next rising edge samples start
    task automatic run_op(input vec_t v, input string tag);
        int early = 0;
        dividendin = v.a; divisorin = v.b; signedin = v.s; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk({tag, " valid_clr"}, 64'(valid), 64'd0);
        chk({tag, " error_clr"}, 64'(error), 64'd0);
        for (int i = 1; i < LAT; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                // Operands are captured; anything driven now must be ignored
                dividendin = W'($urandom);
                divisorin  = DW'($urandom);
                signedin   = 1'($urandom);
            end
            if (i == LAT / 2) chk({tag, " busy_run"}, 64'(busy), 64'd1);
            if (valid) early++;
        end
        @(posedge clk); #1;
        chk({tag, " early_valid"}, 64'(early), 64'd0);
        chk({tag, " valid"}, 64'(valid), 64'd1);
        chk({tag, " busy_done"}, 64'(busy), 64'd0);
        chk({tag, " q"}, 64'(quotient), 64'(v.q));
        chk({tag, " r"}, 64'(remainder), 64'(v.r));
        chk({tag, " err"}, 64'(error), 64'(v.e));
    endtask

    initial begin
        vec_t v;
        int   cnt;

        tbl[0] = '{8'd200, 7'd7,   1'b0, 8'd28,  7'd4,  1'b0};
        tbl[1] = '{8'd100, 7'd0,   1'b0, 8'hFF,  7'd0,  1'b1};
        tbl[2] = '{8'h9C,  7'h07,  1'b1, 8'hF2,  7'h7E, 1'b0};
        tbl[3] = '{8'h80,  7'h7F,  1'b1, 8'h80,  7'd0,  1'b0};
        tbl[4] = '{8'd0,   7'd5,   1'b0, 8'd0,   7'd0,  1'b0};
        tbl[5] = '{8'd255, 7'd1,   1'b0, 8'hFF,  7'd0,  1'b0};
        tbl[6] = '{8'd5,   7'd127, 1'b0, 8'd0,   7'd5,  1'b0};
        tbl[7] = '{8'h7F,  7'h40,  1'b1, 8'hFF,  7'h3F, 1'b0};
        tbl[8] = '{8'h9C,  7'd0,   1'b1, 8'hFF,  7'd0,  1'b1};
        tbl[9] = '{8'h81,  7'h7E,  1'b1, 8'h3F,  7'h7F, 1'b0};

        // Reset state, held from time zero
        #12;
        chk("rst q", 64'(quotient), 64'd0);
        chk("rst r", 64'(remainder), 64'd0);
        chk("rst valid", 64'(valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst err", 64'(error), 64'd0);

        // Release mid-cycle; the first edge after release samples start
        @(posedge clk); #3 reset = 1'b1;

        for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

        // Random vectors, biased towards zero divisors and signed extremes
        for (int i = 0; i < 40; i++) begin
            v.a = W'($urandom);
            v.b = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
            v.s = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                v.a = 8'h80; v.b = 7'h7F; v.s = 1'b1;
            end
            model(v.a, v.b, v.s, v.q, v.r, v.e);
            run_op(v, $sformatf("rnd%0d", i));
        end

        // Abort: restart 5 cycles after the first start with new operands
        dividendin = 8'd200; divisorin = 7'd7; signedin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        for (int i = 1; i < 5; i++) begin
            @(posedge clk); #1;
            if (valid) cnt++;
        end
        chk("abort pre_valid", 64'(cnt), 64'd0);
        v = '{8'd50, 7'd3, 1'b0, 8'd16, 7'd2, 1'b0};
        run_op(v, "abort");

        // Reset during RUN clears every output without waiting for a clock
        dividendin = 8'd200; divisorin = 7'd7; signedin = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("midrst q", 64'(quotient), 64'd0);
        chk("midrst r", 64'(remainder), 64'd0);
        chk("midrst valid", 64'(valid), 64'd0);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst err", 64'(error), 64'd0);
        @(posedge clk); #3 reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid || busy) cnt++;
        end
        chk("postrst idle", 64'(cnt), 64'd0);
        run_op(tbl[2], "postrst");

        // Wide instance: 65535 / 4095
        dividend2 = 16'hFFFF; divisor2 = 12'hFFF; start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        cnt = 0;
        for (int i = 1; i < 33; i++) begin
            @(posedge clk); #1;
            if (valid2) cnt++;
        end
        chk("wide early_valid", 64'(cnt), 64'd0);
        @(posedge clk); #1;
        chk("wide valid", 64'(valid2), 64'd1);
        chk("wide q", 64'(quotient2), 64'd16);
        chk("wide r", 64'(remainder2), 64'd15);
        chk("wide err", 64'(error2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
